// File: rtl/memctrl_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : memctrl_seq_pkg
// Purpose  : Shared types and constants for the MEMCTRL host sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package memctrl_seq_pkg;

    // Default build parameters.
    localparam int CE_HALF_DEF = 3;
    localparam int ADDR_W_DEF  = 16;
    localparam int DATA_W_DEF  = 8;

    // Requester port indices: SoC bus bridge and debug/scan host.
    localparam int PORT_BUS = 0;
    localparam int PORT_DBG = 1;

    // Sequencer states; one full MEMCTRL access is SETUP + two CE pulses + RESP.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_CE1_HI = 3'd2,
        S_CE1_LO = 3'd3,
        S_CE2_HI = 3'd4,
        S_CE2_LO = 3'd5,
        S_RESP   = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Purpose  : Two-way round-robin arbiter. A lone requester always wins; on a
//            tie the port not granted last wins. The pointer moves only when
//            the grant is actually taken (advance_i).
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] grant_o
);

    // Port that wins a tie; resets to favour port 0.
    logic ptr_q;

    // Grant selection from the current requests and tie-break pointer.
    always_comb begin
        grant_o = 2'b00;
        case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = ptr_q ? 2'b10 : 2'b01;
            default: grant_o = 2'b00;
        endcase
    end

    // After port 0 is served, favour port 1 next time, and vice versa.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= 1'b0;
        end else if (advance_i) begin
            ptr_q <= grant_o[0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/memctrl_host_seq.sv
`default_nettype none
// ============================================================================
// Module   : memctrl_host_seq
// Purpose  : Two-port host sequencer/arbiter in front of MEMCTRL. Accepts a
//            request, runs the two-pulse CE cycle, samples read data and
//            returns a one-cycle response. All outputs are registered.
// Revision : 1.0 - initial release
// ============================================================================
module memctrl_host_seq
    import memctrl_seq_pkg::*;
#(
    parameter int CE_HALF = CE_HALF_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [1:0]          req_valid_i,
    input  logic [1:0]          req_wr_i,
    input  logic [2*ADDR_W-1:0] req_addr_i,
    input  logic [2*DATA_W-1:0] req_wdata_i,
    output logic [1:0]          req_ready_o,
    output logic [1:0]          rsp_valid_o,
    output logic [DATA_W-1:0]   rsp_rdata_o,
    input  logic                bist_hold_i,
    output logic                idle_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_idata_o,
    output logic                mem_ce_o,
    output logic                mem_csb_o,
    output logic                mem_web_o,
    output logic                mem_oeb_o,
    input  logic [DATA_W-1:0]   mem_odata_i
);

    // Last count value of each CE half-period.
    localparam logic [3:0] CNT_LAST = 4'(CE_HALF - 1);

    state_t              state_q;
    logic [3:0]          cnt_q;
    logic                wr_q;
    logic                port_q;
    logic [1:0]          req_ready_q;
    logic [1:0]          rsp_valid_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic                idle_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_idata_q;
    logic                mem_ce_q;
    logic                mem_csb_q;
    logic                mem_web_q;
    logic                mem_oeb_q;

    logic [1:0]          arb_grant;
    logic                accept;
    logic                sel_port;
    logic                sel_wr;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                cnt_last;

    // A grant is taken only from idle and only while BIST is not holding the bus.
    assign accept    = (state_q == S_IDLE) && !bist_hold_i && (|req_valid_i);
    assign sel_port  = arb_grant[PORT_DBG];
    assign sel_wr    = sel_port ? req_wr_i[PORT_DBG] : req_wr_i[PORT_BUS];
    assign sel_addr  = sel_port ? req_addr_i[PORT_DBG*ADDR_W +: ADDR_W]
                                : req_addr_i[PORT_BUS*ADDR_W +: ADDR_W];
    assign sel_wdata = sel_port ? req_wdata_i[PORT_DBG*DATA_W +: DATA_W]
                                : req_wdata_i[PORT_BUS*DATA_W +: DATA_W];
    assign cnt_last  = (cnt_q == CNT_LAST);

    rr_arb2 u_arb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (req_valid_i),
        .advance_i (accept),
        .grant_o   (arb_grant)
    );

    // Sequencer FSM: every MEMCTRL pin and handshake output is set one edge ahead.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            wr_q        <= 1'b0;
            port_q      <= 1'b0;
            req_ready_q <= 2'b00;
            rsp_valid_q <= 2'b00;
            rsp_rdata_q <= '0;
            idle_q      <= 1'b1;
            mem_addr_q  <= '0;
            mem_idata_q <= '0;
            mem_ce_q    <= 1'b0;
            mem_csb_q   <= 1'b1;
            mem_web_q   <= 1'b1;
            mem_oeb_q   <= 1'b1;
        end else begin
            req_ready_q <= 2'b00;
            rsp_valid_q <= 2'b00;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        state_q     <= S_SETUP;
                        req_ready_q <= arb_grant;
                        port_q      <= sel_port;
                        wr_q        <= sel_wr;
                        mem_addr_q  <= sel_addr;
                        mem_idata_q <= sel_wdata;
                        mem_csb_q   <= 1'b0;
                        mem_web_q   <= ~sel_wr;
                        mem_oeb_q   <= sel_wr;
                        idle_q      <= 1'b0;
                    end
                end
                S_SETUP: begin
                    // CSB/WEB stay low into the first CE-high cycle.
                    state_q  <= S_CE1_HI;
                    cnt_q    <= 4'd0;
                    mem_ce_q <= 1'b1;
                end
                S_CE1_HI: begin
                    mem_csb_q <= 1'b1;
                    mem_web_q <= 1'b1;
                    if (cnt_last) begin
                        state_q  <= S_CE1_LO;
                        cnt_q    <= 4'd0;
                        mem_ce_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                S_CE1_LO: begin
                    if (cnt_last) begin
                        state_q  <= S_CE2_HI;
                        cnt_q    <= 4'd0;
                        mem_ce_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                S_CE2_HI: begin
                    // Read data is valid during the first CE2-high cycle; OEB releases after it.
                    if (cnt_q == 4'd0) begin
                        if (!wr_q) begin
                            rsp_rdata_q <= mem_odata_i;
                        end
                        mem_oeb_q <= 1'b1;
                    end
                    if (cnt_last) begin
                        state_q  <= S_CE2_LO;
                        cnt_q    <= 4'd0;
                        mem_ce_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                S_CE2_LO: begin
                    if (cnt_last) begin
                        state_q     <= S_RESP;
                        cnt_q       <= 4'd0;
                        rsp_valid_q <= {port_q, ~port_q};
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                    idle_q  <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                    idle_q  <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign idle_o      = idle_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_idata_o = mem_idata_q;
    assign mem_ce_o    = mem_ce_q;
    assign mem_csb_o   = mem_csb_q;
    assign mem_web_o   = mem_web_q;
    assign mem_oeb_o   = mem_oeb_q;

endmodule
`default_nettype wire

// File: tb/tb_memctrl_host_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_memctrl_host_seq
// Purpose  : Directed self-checking bench for memctrl_host_seq with a small
//            MEMCTRL stand-in and a response scoreboard. A second instance
//            built with CE_HALF=1 covers the short-cycle case.
// Revision : 1.0 - initial release
// ============================================================================
module tb_memctrl_host_seq;

    localparam int AW = 16;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Instance with default CE_HALF=3
    logic [1:0]      req_valid = '0;
    logic [1:0]      req_wr    = '0;
    logic [2*AW-1:0] req_addr  = '0;
    logic [2*DW-1:0] req_wdata = '0;
    logic            bist      = 1'b0;
    logic [1:0]      req_ready, rsp_valid;
    logic [DW-1:0]   rsp_rdata, mem_idata, mem_odata;
    logic [AW-1:0]   mem_addr;
    logic            idle, mem_ce, mem_csb, mem_web, mem_oeb;

    // Instance with CE_HALF=1
    logic [1:0]      req_valid1 = '0;
    logic [1:0]      req_wr1    = '0;
    logic [2*AW-1:0] req_addr1  = '0;
    logic [1:0]      req_ready1, rsp_valid1;
    logic [DW-1:0]   rsp_rdata1, mem_idata1, mem_odata1;
    logic [AW-1:0]   mem_addr1;
    logic            idle1, mem_ce1, mem_csb1, mem_web1, mem_oeb1;

    memctrl_host_seq #(.CE_HALF(3), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_wr_i(req_wr), .req_addr_i(req_addr),
        .req_wdata_i(req_wdata), .req_ready_o(req_ready), .rsp_valid_o(rsp_valid),
        .rsp_rdata_o(rsp_rdata), .bist_hold_i(bist), .idle_o(idle),
        .mem_addr_o(mem_addr), .mem_idata_o(mem_idata), .mem_ce_o(mem_ce),
        .mem_csb_o(mem_csb), .mem_web_o(mem_web), .mem_oeb_o(mem_oeb),
        .mem_odata_i(mem_odata)
    );

    memctrl_host_seq #(.CE_HALF(1), .ADDR_W(AW), .DATA_W(DW)) dut1 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid1), .req_wr_i(req_wr1), .req_addr_i(req_addr1),
        .req_wdata_i(16'h0000), .req_ready_o(req_ready1), .rsp_valid_o(rsp_valid1),
        .rsp_rdata_o(rsp_rdata1), .bist_hold_i(1'b0), .idle_o(idle1),
        .mem_addr_o(mem_addr1), .mem_idata_o(mem_idata1), .mem_ce_o(mem_ce1),
        .mem_csb_o(mem_csb1), .mem_web_o(mem_web1), .mem_oeb_o(mem_oeb1),
        .mem_odata_i(mem_odata1)
    );

    // MEMCTRL stand-in: write on CE rise with CSB/WEB low, drive ODATA while OEB low.
    logic [7:0] mm [0:255];
    logic       ce_prev = 1'b0;
    assign mem_odata  = mem_oeb ? 8'h00 : mm[mem_addr[7:0]];
    assign mem_odata1 = mem_oeb1 ? 8'h00 : 8'hC3;

    always @(negedge clk) begin
        ce_prev <= mem_ce;
        if (mem_ce && !ce_prev && !mem_csb && !mem_web)
            mm[mem_addr[7:0]] <= mem_idata;
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard of expected responses, in grant order.
    typedef struct {
        logic       port;
        logic       rd;
        logic [7:0] data;
    } sb_t;
    sb_t sbq[$];
    sb_t sb_e;

    always @(negedge clk) begin
        if (!rst && rsp_valid != 2'b00) begin
            check("rsp_expected", 64'(sbq.size() != 0), 64'd1);
            if (sbq.size() != 0) begin
                sb_e = sbq.pop_front();
                check("rsp_port", 64'(rsp_valid), sb_e.port ? 64'd2 : 64'd1);
                if (sb_e.rd) check("rsp_rdata", 64'(rsp_rdata), 64'(sb_e.data));
            end
        end
    end

    // Expected {CE,CSB,WEB,OEB} k cycles after REQ_READY is seen, CE_HALF=3.
    function automatic logic [3:0] exp_ctl3(input int k, input logic wr);
        logic ce, csb, web, oeb;
        ce  = (k >= 1 && k <= 3) || (k >= 7 && k <= 9);
        csb = !(k <= 1);
        web = wr ? !(k <= 1) : 1'b1;
        oeb = wr ? 1'b1 : (k >= 8);
        return {ce, csb, web, oeb};
    endfunction

    task automatic wait_ready(input logic [1:0] mask, input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((req_ready & mask) == 2'b00 && n < 40);
        check({tag, "_seen"}, 64'((req_ready & mask) != 2'b00), 64'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!idle && n < 40);
        check({tag, "_idle"}, 64'(idle), 64'd1);
    endtask

    // Called at the negedge where REQ_READY is seen; walks the CE cycle.
    task automatic trace3(input logic wr, input logic [15:0] a, input logic [7:0] d,
                          input logic [1:0] oh, input string tag);
        for (int k = 0; k <= 12; k++) begin
            check($sformatf("%s_ctl_k%0d", tag, k), 64'({mem_ce, mem_csb, mem_web, mem_oeb}),
                  64'(exp_ctl3(k, wr)));
            check($sformatf("%s_bus_k%0d", tag, k), 64'({mem_addr, mem_idata}), 64'({a, d}));
            @(negedge clk);
        end
        check({tag, "_latency"}, 64'(rsp_valid), 64'(oh));
    endtask

    initial begin
        int seen;

        // Reset takes effect immediately, without a clock edge.
        #1 rst = 1'b1;
        #1;
        check("reset_ctl", 64'({mem_ce, mem_csb, mem_web, mem_oeb, req_ready, rsp_valid, idle}),
              64'({1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 1'b1}));
        check("reset_bus", 64'({mem_addr, mem_idata, rsp_rdata}), 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;

        // Port 0 write 0x1234 <- 0xA5; inputs scrambled after accept.
        req_valid = 2'b01; req_wr = 2'b01;
        req_addr[15:0] = 16'h1234; req_wdata[7:0] = 8'hA5;
        wait_ready(2'b11, "t1_ready");
        check("t1_ready_oh", 64'(req_ready), 64'd1);
        sbq.push_back('{1'b0, 1'b0, 8'h00});
        req_valid = 2'b00; req_addr = '1; req_wdata = '1; req_wr = 2'b00;
        trace3(1'b1, 16'h1234, 8'hA5, 2'b01, "t1");
        wait_idle("t1");

        // Port 1 read 0x1234 -> 0xA5.
        @(posedge clk); #1;
        req_valid = 2'b10; req_wr = 2'b00; req_addr[31:16] = 16'h1234;
        wait_ready(2'b11, "t2_ready");
        check("t2_ready_oh", 64'(req_ready), 64'd2);
        sbq.push_back('{1'b1, 1'b1, 8'hA5});
        req_valid = 2'b00;
        trace3(1'b0, 16'h1234, 8'hFF, 2'b10, "t2");
        wait_idle("t2");

        // Both ports requesting continuously: grants alternate 0,1,0,1.
        @(posedge clk); #1;
        req_valid = 2'b11; req_wr = 2'b01;
        req_addr = {16'h1234, 16'h0020}; req_wdata = {8'h00, 8'h5A};
        for (int i = 0; i < 4; i++) begin
            wait_ready(2'b11, $sformatf("t3_ready%0d", i));
            check($sformatf("t3_order%0d", i), 64'(req_ready), (i % 2) ? 64'd2 : 64'd1);
            check($sformatf("t3_ce_gap%0d", i), 64'(mem_ce), 64'd0);
            if (i % 2) sbq.push_back('{1'b1, 1'b1, 8'hA5});
            else       sbq.push_back('{1'b0, 1'b0, 8'h00});
        end
        req_valid = 2'b00;
        wait_idle("t3");

        // BIST hold blocks grants; release grants on the next cycle.
        @(posedge clk); #1;
        bist = 1'b1;
        req_valid = 2'b01; req_wr = 2'b01;
        req_addr[15:0] = 16'h0030; req_wdata[7:0] = 8'h77;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("t4_hold%0d", i), 64'({req_ready, idle}), 64'd1);
        end
        @(posedge clk); #1 bist = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t4_release_grant", 64'(req_ready), 64'd1);
        sbq.push_back('{1'b0, 1'b0, 8'h00});
        req_valid = 2'b00;
        // Hold rises mid-transaction: transaction completes, port 1 waits.
        bist = 1'b1;
        req_valid = 2'b10; req_wr = 2'b00; req_addr[31:16] = 16'h0030;
        wait_idle("t4a");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("t4_blocked%0d", i), 64'(req_ready), 64'd0);
        end
        @(posedge clk); #1 bist = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t4_held_req_grant", 64'(req_ready), 64'd2);
        sbq.push_back('{1'b1, 1'b1, 8'h77});
        req_valid = 2'b00;
        wait_idle("t4b");

        // Reset in the first CE1_LO cycle: immediate bus release, no response.
        @(posedge clk); #1;
        req_valid = 2'b01; req_wr = 2'b01;
        req_addr[15:0] = 16'h0040; req_wdata[7:0] = 8'h99;
        wait_ready(2'b11, "t5_ready");
        req_valid = 2'b00;
        for (int k = 0; k < 4; k++) @(negedge clk);
        rst = 1'b1;
        #1;
        check("t5_rst_ctl", 64'({mem_ce, mem_csb, mem_web, mem_oeb, req_ready, rsp_valid, idle}),
              64'({1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 1'b1}));
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (rsp_valid != 2'b00) seen++;
        end
        check("t5_no_rsp", 64'(seen), 64'd0);
        @(posedge clk); #1;
        req_valid = 2'b11; req_wr = 2'b01;
        req_addr = {16'h1234, 16'h0050}; req_wdata = {8'h00, 8'h01};
        wait_ready(2'b11, "t5_first");
        check("t5_ptr_reset", 64'(req_ready), 64'd1);
        sbq.push_back('{1'b0, 1'b0, 8'h00});
        req_valid = 2'b10;
        wait_ready(2'b11, "t5_second");
        check("t5_second_port", 64'(req_ready), 64'd2);
        sbq.push_back('{1'b1, 1'b1, 8'hA5});
        req_valid = 2'b00;
        wait_idle("t5");

        // CE_HALF=1 read: 6 cycles from accept, OEB high in CE2_LO.
        @(posedge clk); #1;
        req_valid1 = 2'b01; req_wr1 = 2'b00; req_addr1[15:0] = 16'h0001;
        seen = 0;
        do begin
            @(negedge clk);
            seen++;
        end while (req_ready1 == 2'b00 && seen < 40);
        check("h1_ready", 64'(req_ready1), 64'd1);
        req_valid1 = 2'b00;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 3) check("h1_oeb_ce2hi", 64'({mem_ce1, mem_oeb1}), 64'b10);
            if (k == 4) check("h1_oeb_ce2lo", 64'({mem_ce1, mem_oeb1, rsp_valid1}), 64'b0100);
            if (k == 5) check("h1_rsp", 64'({rsp_valid1, rsp_rdata1}), 64'({2'b01, 8'hC3}));
        end

        repeat (3) @(negedge clk);
        check("sb_drained", 64'(sbq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/memctrl_host_seq.md
Name: memctrl_host_seq

Overview:
Two-port host sequencer and arbiter in front of MEMCTRL. It accepts read and write requests from two requesters over a valid/ready handshake and arbitrates between them round-robin. For each granted request it generates the MEMCTRL two-pulse CE cycle (CSB/WEB/OEB/ADDR/IDATA), samples ODATA for reads, and returns a one-cycle response. It sits between the SoC bus bridge (port 0) and the debug/scan host (port 1) on one side and MEMCTRL on the other.

Parameters:
CE_HALF, 3, clock cycles per CE half-period (CE cycle = 2*CE_HALF); legal range 1..15
ADDR_W, 16, address width
DATA_W, 8, data width

Ports:
CLK  in  1  clock; all state updates on the rising edge
RST  in  1  asynchronous reset, active-high
REQ_VALID  in  2  per-port request valid; bit n = port n
REQ_WR  in  2  per-port request type: 1 = write, 0 = read
REQ_ADDR  in  2*ADDR_W  port n address at [n*ADDR_W +: ADDR_W]
REQ_WDATA  in  2*DATA_W  port n write data at [n*DATA_W +: DATA_W]
REQ_READY  out  2  one-hot grant/accept pulse
RSP_VALID  out  2  one-hot completion pulse, one cycle
RSP_RDATA  out  DATA_W  read data; valid when RSP_VALID is set for a read
BIST_HOLD  in  1  when 1, no new grants are issued (MEMCTRL in BIST)
IDLE  out  1  1 when no transaction is in flight
MEM_ADDR  out  ADDR_W  to MEMCTRL ADDR
MEM_IDATA  out  DATA_W  to MEMCTRL IDATA
MEM_CE  out  1  to MEMCTRL CE
MEM_CSB  out  1  to MEMCTRL CSB, active low
MEM_WEB  out  1  to MEMCTRL WEB, active low
MEM_OEB  out  1  to MEMCTRL OEB, active low
MEM_ODATA  in  DATA_W  from MEMCTRL ODATA

Behaviour:
- Reset values: MEM_CE=0, MEM_CSB=1, MEM_WEB=1, MEM_OEB=1, MEM_ADDR=0, MEM_IDATA=0, REQ_READY=0, RSP_VALID=0, RSP_RDATA=0, IDLE=1, state=S_IDLE, round-robin pointer favours port 0.
- All outputs are registered. A single cycle counter cnt, width 4, counts 0..CE_HALF-1.
- S_IDLE: if BIST_HOLD=0 and any REQ_VALID, grant one port, pulse REQ_READY[n] for that cycle, and capture wr/addr/wdata. Next state is S_SETUP.
- Arbitration: the sole requester wins. If both request, the port not granted last wins; the pointer updates on each grant only.
- S_SETUP (1 cycle): MEM_ADDR/MEM_IDATA driven from the captured request, MEM_CSB=0, MEM_WEB=~wr, MEM_OEB=wr, MEM_CE=0.
- S_CE1_HI (CE_HALF cycles): MEM_CE=1. CSB and WEB stay low only in the first cycle, then return to 1.
- S_CE1_LO (CE_HALF cycles): MEM_CE=0.
- S_CE2_HI (CE_HALF cycles): MEM_CE=1.
  - For a read, MEM_ODATA is sampled into RSP_RDATA at the end of the first S_CE2_HI cycle.
  - MEM_OEB returns to 1 from the second cycle onward; with CE_HALF=1 it returns to 1 on exit.
- S_CE2_LO (CE_HALF cycles): MEM_CE=0.
- S_RESP (1 cycle): RSP_VALID[n]=1; RSP_RDATA holds for a read and is unchanged for a write. Next state is S_IDLE.
- Latency: from the accept cycle to RSP_VALID is 2+4*CE_HALF cycles (14 at default). A new grant is possible in the cycle after S_RESP.
- MEM_ADDR and MEM_IDATA hold their value from S_SETUP through S_RESP and keep the last value in S_IDLE.
- IDLE=1 only in S_IDLE.
- BIST_HOLD rising mid-transaction does not abort the transaction; it blocks only the next grant. REQ_VALID held while blocked must not be dropped.
- REQ_VALID deasserted before grant: no transaction and no REQ_READY.
- RST asserted at any time: all outputs take their reset values immediately. An in-flight transaction is discarded with no RSP_VALID, and the pointer resets to port 0.
- The accepted request is captured; requester inputs may change after REQ_READY without affecting the cycle.

Decomposition:
- Package memctrl_seq_pkg: state enum (S_IDLE, S_SETUP, S_CE1_HI, S_CE1_LO, S_CE2_HI, S_CE2_LO, S_RESP), default CE_HALF/ADDR_W/DATA_W constants, port-index constants.
- Sub-module rr_arb2: two-way round-robin arbiter with req[1:0], an advance strobe, grant[1:0] and its own pointer register.

Test Plan:
- Port 0 write of addr 0x1234, data 0xA5 -> REQ_READY[0] pulse; CSB=0 and WEB=0 for exactly 1 cycle at the first CE rise; two CE pulses of 3 high / 3 low; RSP_VALID[0] 14 cycles after accept.
- Port 1 read of 0x1234 with a MEMCTRL model returning 0xA5 -> OEB low from S_SETUP through the first S_CE2_HI cycle; RSP_RDATA=0xA5 with RSP_VALID[1].
- Both ports requesting continuously for 4 transactions -> grant order 0,1,0,1; no CE overlap between transactions.
- BIST_HOLD=1 while port 0 requests -> no REQ_READY and IDLE stays 1; on release, grant on the next cycle.
- RST pulse during S_CE1_LO -> CE=0, CSB=WEB=OEB=1 immediately; no RSP_VALID; after release, a port 1 request is granted only after port 0 if both request.
- CE_HALF=1 build with a read -> latency 6 cycles; data sampled correctly; OEB high in S_CE2_LO.
